// File: rtl/ssd_pkg.sv
// ssd_pkg: shared seven-segment constants, encodings and helpers.
// Contents: seg_t pattern type, SEG_BLANK, SEG_DASH, SEG_HEX[0..15] (all active-low, bit order gfedcba),
//           AN_OFF(w) returning an all-ones anode word of width w.
package ssd_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;
    localparam seg_t SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    function automatic logic [31:0] AN_OFF(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : (32'h1 << w) - 32'h1;
    endfunction
endpackage

// File: rtl/ssd_tick_gen.sv
// ssd_tick_gen: enabled modulo-TICK_DIV counter emitting a one-cycle tick on its last count.
// Ports: clk, rst_n (async active-low), i_en (count enable), o_tick (high when enabled at count TICK_DIV-1).
module ssd_tick_gen #(
    parameter int TICK_DIV = 1563
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
    logic [W-1:0] r_cnt;
    assign o_tick = i_en && (r_cnt == LAST);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (i_en) r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/ssd_mux.sv
// ssd_mux: time-multiplexed seven-segment driver with per-digit dp, blanking and PWM brightness.
// Ports: clk, rst_n (async active-low), seg_in[DIGITS][7] (active-low patterns), dp_in, digit_en,
//        brightness, [blink_mask when SSD_MUX_BLINK_EN], an (active-low one-cold), seg, dp (active-low).
// Optional feature: define SSD_MUX_BLINK_EN to add per-digit blinking with a BLINK_FRAMES half-period.
module ssd_mux
    import ssd_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int TICK_DIV     = 1563,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIGITS-1:0][6:0] seg_in,
    input  logic [DIGITS-1:0]      dp_in,
    input  logic [DIGITS-1:0]      digit_en,
    input  logic [BRIGHT_W-1:0]    brightness,
`ifdef SSD_MUX_BLINK_EN
    input  logic [DIGITS-1:0]      blink_mask,
`endif
    output logic [DIGITS-1:0]      an,
    output logic [6:0]             seg,
    output logic                   dp
);
    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    logic                w_tick, w_slot, w_frame, w_load, w_en, w_lit;
    logic [IW-1:0]       r_idx, w_idx_nxt;
    logic [BRIGHT_W-1:0] r_sub, r_bright;
    logic                r_first, r_dp, r_en, r_dp_o;
    seg_t                r_seg, r_seg_o;
    logic [DIGITS-1:0]   r_an;
    ssd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (1'b1),
        .o_tick (w_tick)
    );
    // A slot ends when the last subslot ticks; the frame ends when that happens on the last digit.
    assign w_slot    = w_tick && (r_sub == '1);
    assign w_frame   = w_slot && (r_idx == IDX_LAST);
    assign w_idx_nxt = w_frame ? '0 : (w_slot ? r_idx + 1'b1 : r_idx);
    // Latches load on the same edge idx advances so they always describe the current slot.
    assign w_load    = w_slot || r_first;
`ifdef SSD_MUX_BLINK_EN
    logic w_blink_tgl, r_off, r_mask;
    ssd_tick_gen #(.TICK_DIV(BLINK_FRAMES)) u_blink (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_frame),
        .o_tick (w_blink_tgl)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_off  <= 1'b0;
            r_mask <= 1'b0;
        end else begin
            if (w_blink_tgl) r_off <= ~r_off;
            if (w_load) r_mask <= blink_mask[w_idx_nxt];
        end
    end
    assign w_en = r_en && !(r_off && r_mask);
`else
    logic w_unused_blink;
    assign w_unused_blink = ^BLINK_FRAMES;
    assign w_en = r_en;
`endif
    assign w_lit = w_en && (r_sub <= r_bright);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first  <= 1'b1;
            r_idx    <= '0;
            r_sub    <= '0;
            r_seg    <= SEG_BLANK;
            r_dp     <= 1'b0;
            r_en     <= 1'b0;
            r_bright <= '0;
        end else begin
            r_first <= 1'b0;
            r_idx   <= w_idx_nxt;
            if (w_tick) r_sub <= r_sub + 1'b1;
            if (w_load) begin
                r_seg <= seg_in[w_idx_nxt];
                r_dp  <= dp_in[w_idx_nxt];
                r_en  <= digit_en[w_idx_nxt];
            end
            if (w_frame || r_first) r_bright <= brightness;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an    <= DIGITS'(AN_OFF(DIGITS));
            r_seg_o <= SEG_BLANK;
            r_dp_o  <= 1'b1;
        end else begin
            r_an    <= w_lit ? ~(DIGITS'(1) << r_idx) : DIGITS'(AN_OFF(DIGITS));
            r_seg_o <= w_lit ? r_seg : SEG_BLANK;
            r_dp_o  <= !(w_lit && r_dp);
        end
    end
    assign an  = r_an;
    assign seg = r_seg_o;
    assign dp  = r_dp_o;
endmodule

// File: tb/tb_ssd_mux.sv
// tb_ssd_mux: directed self-checking bench for ssd_mux with DIGITS=4, TICK_DIV=2, BRIGHT_W=2, BLINK_FRAMES=2.
module tb_ssd_mux;
    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0][6:0] seg_in;
    logic [3:0]      dp_in, digit_en, blink_mask;
    logic [1:0]      brightness;
    logic [3:0]      an;
    logic [6:0]      seg;
    logic            dp;
    int              checks = 0;
    int              errors = 0;
    logic [6:0]      es [4];
    int              el [4];
    logic            ed [4];
    ssd_mux #(.DIGITS(4), .TICK_DIV(2), .BRIGHT_W(2), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .brightness (brightness),
`ifdef SSD_MUX_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        checks++;
        assert ($countones(~an) <= 1) else begin
            errors++;
            $error("FAIL overlap: an=%b required at most one low bit", an);
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_pins(input string tag, input logic [11:0] exp);
        checks++;
        assert ({an, seg, dp} === exp) else begin
            errors++;
            $error("FAIL %s: an/seg/dp=%b/%h/%b required %b/%h/%b", tag, an, seg, dp, exp[11:8], exp[7:1], exp[0]);
        end
    endtask
    // Positions k of a digit slot: two clk per subslot, lit while k < lit.
    task automatic chk_slot(input int d, input int k0, input int k1, input int lit, input logic [6:0] sv, input logic dv);
        logic [3:0] a;
        for (int k = k0; k <= k1; k++) begin
            step();
            a = ~(4'b0001 << d);
            chk_pins($sformatf("slot d%0d k%0d", d, k), (k < lit) ? {a, sv, ~dv} : {4'hF, 7'h7F, 1'b1});
        end
    endtask
    task automatic chk_frame();
        for (int d = 0; d < 4; d++) chk_slot(d, 0, 7, el[d], es[d], ed[d]);
    endtask
    initial begin
        rst_n      = 1'b0;
        seg_in     = {7'h01, 7'h02, 7'h04, 7'h08};
        dp_in      = 4'b0000;
        digit_en   = 4'b1111;
        brightness = 2'd3;
        blink_mask = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk_pins("reset", {4'hF, 7'h7F, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_pins("first edge", {4'hF, 7'h7F, 1'b1});
        es = '{7'h08, 7'h04, 7'h02, 7'h01};
        el = '{8, 8, 8, 8};
        ed = '{1'b0, 1'b0, 1'b0, 1'b0};
        chk_slot(0, 1, 7, 8, es[0], ed[0]);
        for (int d = 1; d < 4; d++) chk_slot(d, 0, 7, el[d], es[d], ed[d]);
        brightness = 2'd1;
        chk_frame();
        el = '{4, 4, 4, 4};
        chk_frame();
        brightness = 2'd0;
        chk_frame();
        el = '{2, 2, 2, 2};
        chk_frame();
        brightness = 2'd3;
        digit_en   = 4'b1011;
        dp_in      = 4'b0001;
        el = '{2, 2, 0, 2};
        chk_frame();
        el = '{8, 8, 0, 8};
        ed = '{1'b1, 1'b0, 1'b0, 1'b0};
        chk_frame();
        digit_en = 4'b1111;
        el[2] = 8;
        chk_slot(0, 0, 7, 8, es[0], ed[0]);
        chk_slot(1, 0, 3, 8, es[1], ed[1]);
        seg_in[1] = 7'h55;
        chk_slot(1, 4, 7, 8, es[1], ed[1]);
        chk_slot(2, 0, 7, 8, es[2], ed[2]);
        chk_slot(3, 0, 7, 8, es[3], ed[3]);
        es[1] = 7'h55;
        chk_frame();
        chk_slot(0, 0, 7, 8, es[0], ed[0]);
        chk_slot(1, 0, 7, 8, es[1], ed[1]);
        chk_slot(2, 0, 2, 8, es[2], ed[2]);
        #3;
        rst_n = 1'b0;
        #1;
        chk_pins("async reset", {4'hF, 7'h7F, 1'b1});
`ifdef SSD_MUX_BLINK_EN
        blink_mask = 4'b0010;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_pins("restart first edge", {4'hF, 7'h7F, 1'b1});
        chk_slot(0, 1, 7, 8, es[0], ed[0]);
        for (int d = 1; d < 4; d++) chk_slot(d, 0, 7, el[d], es[d], ed[d]);
`ifdef SSD_MUX_BLINK_EN
        chk_frame();
        el[1] = 0;
        chk_frame();
        chk_frame();
        el[1] = 8;
        chk_frame();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
